// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: FSM states and channel/frame helpers shared by the ADC scan sampler
package adc_spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    // Lowest set bit of mask above cur, wrapping to the lowest set bit; 0 for an empty mask
    function automatic logic [2:0] next_chan(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] lo = '0;
        logic [2:0] hi = '0;
        logic any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) lo = 3'(i);
            if (mask[i] && i > int'(cur)) begin
                hi = 3'(i);
                any = 1'b1;
            end
        end
        return any ? hi : lo;
    endfunction

    // MOSI word: channel address at addr_lsb, every other bit zero
    function automatic logic [31:0] frame_word(input logic [2:0] chan, input int addr_lsb);
        return 32'(chan) << addr_lsb;
    endfunction

endpackage

// File: rtl/adc_scan_spi_if.sv
// adc_scan_spi_if: result stream (valid/ready, data, source channel)
//   master: drives valid, data, chan; receives ready
//   slave : receives valid, data, chan; drives ready
interface adc_scan_spi_if #(parameter int DATAW = 12, parameter int CHW = 3);
    logic             valid;
    logic             ready;
    logic [DATAW-1:0] data;
    logic [CHW-1:0]   chan;
    modport master(output valid, data, chan, input ready);
    modport slave(input valid, data, chan, output ready);
endinterface

// File: rtl/spi_clkgen.sv
// spi_clkgen: CLKDIV half-period timer and SCLK phase tracker
//   en           : count while the sampler is not idle
//   shift        : SHIFT state; phase toggles only here (0 = leading half)
//   half_tick    : last clk cycle of a half-period (also paces SETUP/HOLD)
//   lead_end     : last clk cycle of a leading half, MISO sample point
//   period_start : next cycle may begin a new SCLK period (end of SETUP or of a trailing half)
module spi_clkgen #(parameter int CLKDIV = 2) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic shift,
    output logic half_tick,
    output logic lead_end,
    output logic period_start
);
    localparam int CW = CLKDIV > 1 ? $clog2(CLKDIV) : 1;
    logic [CW-1:0] cnt;
    logic          phase;
    assign half_tick    = en && cnt == CW'(CLKDIV - 1);
    assign lead_end     = half_tick && shift && !phase;
    assign period_start = half_tick && (!shift || phase);
    always_ff @(posedge clk) begin
        cnt   <= (reset || !en || half_tick) ? '0 : cnt + 1'b1;
        phase <= (reset || !shift) ? 1'b0 : phase ^ half_tick;
    end
endmodule

// File: rtl/adc_scan_spi.sv
// adc_scan_spi: channel-scanning SPI sampler for ADC082S021/ADC128S022-style converters
//   clk, reset         : system clock, synchronous active-high reset
//   start, continuous  : begin a scan when idle; keep wrapping while continuous is high
//   chan_mask          : enabled channels, sampled at each frame start
//   busy               : scan in progress
//   m (master)         : result stream, data tagged with source channel
//   overrun/overrun_clr: sticky flag for an overwritten unaccepted result, and its clear
//   sclk, mosi, miso, ss: SPI pins
module adc_scan_spi
    import adc_spi_pkg::*;
#(
    parameter int   NCHAN    = 2,
    parameter int   CHW      = 3,
    parameter int   FRAME    = 16,
    parameter int   ADDR_LSB = 11,
    parameter int   DATAW    = 12,
    parameter int   DATA_LSB = 0,
    parameter int   CLKDIV   = 2,
    parameter logic CPOL     = 1'b0,
    parameter logic SS_IDLE  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic [NCHAN-1:0] chan_mask,
    output logic             busy,
    adc_scan_spi_if.master   m,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             ss
);
    // Bits above the result field simply fall off the top of the shift register
    localparam int SRW = DATA_LSB + DATAW;
    localparam int BW  = $clog2(FRAME);

    state_t           state;
    logic [2:0]       cur, prev;
    logic             prime, flush;
    logic [BW-1:0]    bit_idx;
    logic [SRW-1:0]   sr;
    logic             half_tick, lead_end, period_start, new_res;
    logic [7:0]       mask;
    logic [2:0]       nxt;
    logic [FRAME-1:0] word;

    assign mask    = 8'(chan_mask);
    assign nxt     = next_chan(mask, cur);
    assign word    = FRAME'(frame_word(cur, ADDR_LSB));
    // MISO of the priming frame belongs to no channel we addressed, so it is dropped
    assign new_res = state == SHIFT && period_start && bit_idx == '0 && !prime;

    spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clk          (clk),
        .reset        (reset),
        .en           (state != IDLE),
        .shift        (state == SHIFT),
        .half_tick    (half_tick),
        .lead_end     (lead_end),
        .period_start (period_start)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ss      <= SS_IDLE;
            sclk    <= CPOL;
            mosi    <= 1'b0;
            cur     <= '0;
            prev    <= '0;
            prime   <= 1'b0;
            flush   <= 1'b0;
            bit_idx <= '0;
            sr      <= '0;
            m.valid <= 1'b0;
            m.data  <= '0;
            m.chan  <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && mask != '0) begin
                    state <= SETUP;
                    busy  <= 1'b1;
                    ss    <= ~SS_IDLE;
                    cur   <= next_chan(mask, 3'd7);
                    prime <= 1'b1;
                    flush <= 1'b0;
                end
                SETUP: if (half_tick) begin
                    state   <= SHIFT;
                    sclk    <= ~CPOL;
                    mosi    <= word[FRAME-1];
                    bit_idx <= BW'(FRAME - 1);
                end
                SHIFT: begin
                    if (lead_end) begin
                        sclk <= CPOL;
                        sr   <= {sr[SRW-2:0], miso};
                    end
                    if (period_start) begin
                        if (bit_idx == '0) begin
                            state <= HOLD;
                            ss    <= SS_IDLE;
                            mosi  <= 1'b0;
                        end else begin
                            sclk    <= ~CPOL;
                            mosi    <= word[bit_idx-1];
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                HOLD: if (half_tick) begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= SETUP;
                        ss    <= ~SS_IDLE;
                        prev  <= cur;
                        cur   <= nxt;
                        prime <= 1'b0;
                        // Wrapping past the highest channel ends a single pass with one flush frame
                        flush <= mask == '0 || (nxt <= cur && !continuous);
                    end
                end
                default: state <= IDLE;
            endcase
            if (new_res) begin
                m.valid <= 1'b1;
                m.data  <= sr[DATA_LSB +: DATAW];
                m.chan  <= CHW'(prev);
            end else if (m.ready) begin
                m.valid <= 1'b0;
            end
            overrun <= (new_res && m.valid && !m.ready) || (overrun && !overrun_clr);
        end
    end
endmodule

// File: tb/tb_adc_scan_spi.sv
// tb_adc_scan_spi: scoreboard bench for adc_scan_spi with behavioural ADC models
`timescale 1ns/1ns
module tb_adc_scan_spi;
    typedef struct {
        logic [11:0] d;
        logic [2:0]  c;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, continuous, overrun_clr, busy, overrun, sclk, mosi, ss;
    logic       miso = 1'b0;
    logic [1:0] chan_mask;
    logic       start_b, busy_b, overrun_b, sclk_b, mosi_b, ss_b;
    logic       miso_b = 1'b0;
    logic [1:0] mask_b;

    adc_scan_spi_if #(.DATAW(12), .CHW(3)) sa ();
    adc_scan_spi_if #(.DATAW(8), .CHW(3)) sb ();

    adc_scan_spi dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .chan_mask(chan_mask),
        .busy(busy), .m(sa), .overrun(overrun), .overrun_clr(overrun_clr),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
    );

    adc_scan_spi #(.DATAW(8), .DATA_LSB(4), .CPOL(1'b1), .CLKDIV(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .continuous(1'b0), .chan_mask(mask_b),
        .busy(busy_b), .m(sb), .overrun(overrun_b), .overrun_clr(1'b0),
        .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .ss(ss_b)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    res_t        exp_q[$];
    logic [15:0] exp_w[$];
    longint      t0, t0b;
    int          cyc;
    logic [11:0] base = 12'hABC;
    logic        per_chan = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ADC model (CPOL=0): drives MISO on the leading edge with the result for the
    // channel addressed in the previous complete frame; captures MOSI on the trailing edge
    logic [15:0] resp_a = '0;
    logic [15:0] rx_a = '0;
    int          k_a = 15;
    int          n_rx = 0;
    logic [2:0]  last_a = '0;
    always @(negedge ss) begin
        k_a = 15;
        n_rx = 0;
        resp_a = 16'(per_chan ? base + 12'(last_a) : base);
    end
    always @(posedge sclk) if (ss === 1'b0 && k_a >= 0) begin
        miso = resp_a[k_a];
        k_a--;
    end
    always @(negedge sclk) if (ss === 1'b0) begin
        rx_a = {rx_a[14:0], mosi};
        n_rx++;
    end
    always @(posedge ss) if (n_rx == 16) begin
        last_a = rx_a[13:11];
        n_rx = 0;
        if (exp_w.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mosi_word: got 0x%0h with no frame expected", rx_a);
        end else check("mosi_word", 32'(rx_a), 32'(exp_w.pop_front()));
    end

    // ADC082S021 model (CPOL=1): constant byte 0x5A at frame bits 11..4
    logic [15:0] resp_b = 16'h05A0;
    int          k_b = 15;
    always @(negedge ss_b) k_b = 15;
    always @(negedge sclk_b) if (ss_b === 1'b0 && k_b >= 0) begin
        miso_b = resp_b[k_b];
        k_b--;
    end

    // Result monitor
    always @(negedge clk) if (sa.valid === 1'b1 && sa.ready === 1'b1) begin
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_extra: got data 0x%0h chan %0d with none expected", sa.data, sa.chan);
        end else begin
            res_t e;
            e = exp_q.pop_front();
            check("m_data", 32'(sa.data), 32'(e.d));
            check("m_chan", 32'(sa.chan), 32'(e.c));
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        c = int'(($time - t0 - 5) / 10);
    endtask

    task automatic push_res(input logic [11:0] d, input logic [2:0] c);
        res_t r;
        r.d = d;
        r.c = c;
        exp_q.push_back(r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; chan_mask = '0; overrun_clr = 1'b0;
        sa.ready = 1'b0; start_b = 1'b0; mask_b = '0; sb.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ss", 32'(ss), 1);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(sa.valid), 0);
        check("rst_data", 32'(sa.data), 0);
        check("rst_chan", 32'(sa.chan), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_sclk_b", 32'(sclk_b), 1);
        check("rst_ss_b", 32'(ss_b), 1);

        // Single channel, single pass: priming + flush
        sa.ready = 1'b1; chan_mask = 2'b01; per_chan = 1'b0; base = 12'hABC;
        push_res(12'hABC, 3'd0);
        exp_w.push_back(16'h0000); exp_w.push_back(16'h0000);
        pulse_start();
        wait_idle(cyc);
        check("t1_busy_cycles", 32'(cyc), 136);
        check("t1_pending", 32'(exp_q.size() + exp_w.size()), 0);

        // Two channels, continuous, deasserted during frame 3
        chan_mask = 2'b11; per_chan = 1'b1; base = 12'h100; continuous = 1'b1;
        push_res(12'h100, 3'd0); push_res(12'h101, 3'd1); push_res(12'h100, 3'd0); push_res(12'h101, 3'd1);
        exp_w.push_back(16'h0000); exp_w.push_back(16'h0800); exp_w.push_back(16'h0000);
        exp_w.push_back(16'h0800); exp_w.push_back(16'h0000);
        pulse_start();
        repeat (170) @(posedge clk);
        #1 continuous = 1'b0;
        wait_idle(cyc);
        check("t2_busy_cycles", 32'(cyc), 340);
        check("t2_pending", 32'(exp_q.size() + exp_w.size()), 0);

        // Overrun: two results with no consumer
        sa.ready = 1'b0;
        exp_w.push_back(16'h0000); exp_w.push_back(16'h0800); exp_w.push_back(16'h0000);
        pulse_start();
        wait_idle(cyc);
        check("t3_busy_cycles", 32'(cyc), 204);
        check("t3_overrun", 32'(overrun), 1);
        check("t3_valid", 32'(sa.valid), 1);
        check("t3_data", 32'(sa.data), 32'h101);
        check("t3_chan", 32'(sa.chan), 1);
        push_res(12'h101, 3'd1);
        @(posedge clk);
        #1 sa.ready = 1'b1;
        @(posedge clk);
        #1 check("t3_valid_after_hs", 32'(sa.valid), 0);
        check("t3_overrun_sticky", 32'(overrun), 1);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        check("t3_overrun_clr", 32'(overrun), 0);

        // Clear coinciding with the overwrite: set wins
        sa.ready = 1'b0;
        exp_w.push_back(16'h0000); exp_w.push_back(16'h0800); exp_w.push_back(16'h0000);
        pulse_start();
        repeat (201) @(posedge clk);
        #1 check("t3b_overrun_before", 32'(overrun), 0);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        check("t3b_set_wins", 32'(overrun), 1);
        wait_idle(cyc);
        check("t3b_data", 32'(sa.data), 32'h101);
        push_res(12'h101, 3'd1);
        @(posedge clk);
        #1 sa.ready = 1'b1; overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        check("t3b_pending", 32'(exp_q.size() + exp_w.size()), 0);

        // Reset during frame bit 7, then a fresh scan must prime again
        chan_mask = 2'b01; per_chan = 1'b0; base = 12'h3C5;
        pulse_start();
        repeat (34) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 check("t4_ss", 32'(ss), 1);
        check("t4_sclk", 32'(sclk), 0);
        check("t4_valid", 32'(sa.valid), 0);
        check("t4_busy", 32'(busy), 0);
        reset = 1'b0;
        push_res(12'h3C5, 3'd0);
        exp_w.push_back(16'h0000); exp_w.push_back(16'h0000);
        pulse_start();
        wait_idle(cyc);
        check("t4_busy_cycles", 32'(cyc), 136);
        check("t4_pending", 32'(exp_q.size() + exp_w.size()), 0);

        // Start with an empty mask does nothing
        chan_mask = 2'b00;
        pulse_start();
        cyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || !ss) cyc++;
        end
        check("t5_mask0_active", 32'(cyc), 0);

        // Start while busy does not add frames
        chan_mask = 2'b01; base = 12'hABC;
        push_res(12'hABC, 3'd0);
        exp_w.push_back(16'h0000); exp_w.push_back(16'h0000);
        pulse_start();
        repeat (50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(cyc);
        check("t5_busy_cycles", 32'(cyc), 136);
        check("t5_pending", 32'(exp_q.size() + exp_w.size()), 0);

        // ADC082S021 configuration
        mask_b = 2'b01;
        @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        t0b = $time;
        #1 start_b = 1'b0;
        cyc = 0;
        while (busy_b && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_busy_cycles", 32'(int'(($time - t0b - 5) / 10)), 68);
        check("t6_valid", 32'(sb.valid), 1);
        check("t6_data", 32'(sb.data), 32'h5A);
        check("t6_chan", 32'(sb.chan), 0);
        check("t6_sclk_idle", 32'(sclk_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
